// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the scalar ALU opcode set plus the SIMD lane types.
package cpu_types_pkg;

    localparam int SIMD_LANES = 4;
    localparam int WORD_W     = 32;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef logic [SIMD_LANES-1:0][WORD_W-1:0] simd_word_t;

    typedef struct packed {
        logic of;
        logic zf;
        logic nf;
    } simd_flags_t;

endpackage

// File: rtl/simd_alu_if.sv
// Bundle of the SIMD ALU request/response signals, with ALU-side and bench-side views.
interface simd_alu_if
    import cpu_types_pkg::*;
#(
    parameter int LANES  = SIMD_LANES,
    parameter int WORD_W = cpu_types_pkg::WORD_W
) (
    input logic CLK,
    input logic nRST
);

    logic                    in_valid;
    logic                    in_ready;
    aluop_t                  in_op;
    logic [LANES*WORD_W-1:0] in_porta;
    logic [LANES*WORD_W-1:0] in_portb;
    logic [WORD_W-1:0]       in_scalar_b;
    logic                    in_bcast;
    logic [LANES-1:0]        in_mask;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*WORD_W-1:0] out_result;
    logic [LANES-1:0]        out_of;
    logic [LANES-1:0]        out_zf;
    logic [LANES-1:0]        out_nf;
    logic                    out_any_of;
    logic                    out_all_zf;
    logic                    sticky_of;
    logic                    clr_sticky;

    modport alu (
        input  CLK, nRST, in_valid, in_op, in_porta, in_portb, in_scalar_b,
               in_bcast, in_mask, out_ready, clr_sticky,
        output in_ready, out_valid, out_result, out_of, out_zf, out_nf,
               out_any_of, out_all_zf, sticky_of
    );

    modport tb (
        input  CLK, nRST, in_ready, out_valid, out_result, out_of, out_zf, out_nf,
               out_any_of, out_all_zf, sticky_of,
        output in_valid, in_op, in_porta, in_portb, in_scalar_b, in_bcast,
               in_mask, out_ready, clr_sticky
    );

endinterface

// File: rtl/alu_lane.sv
// One SIMD lane: combinational scalar op set plus raw flags; masking is handled by the caller.
module alu_lane
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = cpu_types_pkg::WORD_W
) (
    input  aluop_t            op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] result,
    output simd_flags_t       flags
);

    localparam int SHW = $clog2(WORD_W);

    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] diff;
    logic [SHW-1:0]    shamt;
    logic              ovf;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    // Select the op result; overflow only exists for ADD/SUB, unknown opcodes give zero.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        flags  = '0;
        case (op)
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_ADD: begin
                result = sum;
                ovf    = ~(a[WORD_W-1] ^ b[WORD_W-1]) & (a[WORD_W-1] ^ sum[WORD_W-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[WORD_W-1] ^ b[WORD_W-1]) & (a[WORD_W-1] ^ diff[WORD_W-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WORD_W-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
        flags.of = ovf;
        flags.zf = (result == '0);
        flags.nf = result[WORD_W-1];
    end

endmodule

// File: rtl/simd_alu.sv
// Two-stage pipelined SIMD ALU: S1 holds the request, S2 holds masked lane results and reduced flags.
module simd_alu
    import cpu_types_pkg::*;
#(
    parameter int LANES  = SIMD_LANES,
    parameter int WORD_W = cpu_types_pkg::WORD_W
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  aluop_t                  in_op,
    input  logic [LANES*WORD_W-1:0] in_porta,
    input  logic [LANES*WORD_W-1:0] in_portb,
    input  logic [WORD_W-1:0]       in_scalar_b,
    input  logic                    in_bcast,
    input  logic [LANES-1:0]        in_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*WORD_W-1:0] out_result,
    output logic [LANES-1:0]        out_of,
    output logic [LANES-1:0]        out_zf,
    output logic [LANES-1:0]        out_nf,
    output logic                    out_any_of,
    output logic                    out_all_zf,
    output logic                    sticky_of,
    input  logic                    clr_sticky
);

    logic                                s1_valid;
    aluop_t                              s1_op;
    logic [LANES-1:0][WORD_W-1:0]        s1_a;
    logic [LANES-1:0][WORD_W-1:0]        s1_b;
    logic [LANES-1:0]                    s1_mask;

    logic [LANES-1:0][WORD_W-1:0]        lane_b;
    logic [WORD_W-1:0]                   lane_res [LANES];
    simd_flags_t                         lane_flags [LANES];

    logic [LANES-1:0][WORD_W-1:0]        nxt_result;
    logic [LANES-1:0]                    nxt_of;
    logic [LANES-1:0]                    nxt_zf;
    logic [LANES-1:0]                    nxt_nf;
    logic                                nxt_any_of;
    logic                                nxt_all_zf;

    logic                                s2_adv;
    logic                                s2_load;

    assign s2_adv   = ~out_valid | out_ready;
    assign s2_load  = s2_adv & s1_valid;
    assign in_ready = ~s1_valid | s2_adv;

    // Pick each lane's B operand: the broadcast scalar or that lane's own slice.
    always_comb begin
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_b[i] = in_bcast ? in_scalar_b : in_portb[i*WORD_W +: WORD_W];
        end
    end

    // S1 captures an accepted request and only advances when S2 can take its contents.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_valid <= 1'b0;
            s1_op    <= ALU_SLL;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mask  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= in_op;
                s1_a    <= in_porta;
                s1_b    <= lane_b;
                s1_mask <= in_mask;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_lane #(
            .WORD_W (WORD_W)
        ) u_lane (
            .op     (s1_op),
            .a      (s1_a[g]),
            .b      (s1_b[g]),
            .result (lane_res[g]),
            .flags  (lane_flags[g])
        );
    end

    // Masked lanes pass A through with all flags low, so they never touch the reductions.
    always_comb begin
        nxt_result = '0;
        nxt_of     = '0;
        nxt_zf     = '0;
        nxt_nf     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_mask[i]) begin
                nxt_result[i] = lane_res[i];
                nxt_of[i]     = lane_flags[i].of;
                nxt_zf[i]     = lane_flags[i].zf;
                nxt_nf[i]     = lane_flags[i].nf;
            end else begin
                nxt_result[i] = s1_a[i];
            end
        end
        nxt_any_of = |nxt_of;
        nxt_all_zf = &(nxt_zf | ~s1_mask);
    end

    // S2 output register: frozen while the consumer stalls, loaded whenever it drains.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_of     <= '0;
            out_zf     <= '0;
            out_nf     <= '0;
            out_any_of <= 1'b0;
            out_all_zf <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= nxt_result;
                out_of     <= nxt_of;
                out_zf     <= nxt_zf;
                out_nf     <= nxt_nf;
                out_any_of <= nxt_any_of;
                out_all_zf <= nxt_all_zf;
            end
        end
    end

    // Sticky overflow: a new overflowing result wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sticky_of <= 1'b0;
        end else if (s2_load && nxt_any_of) begin
            sticky_of <= 1'b1;
        end else if (clr_sticky) begin
            sticky_of <= 1'b0;
        end
    end

endmodule
